// File: rtl/mat_pkg.sv
`default_nettype none
// Shared types and constants for the requantising row drain.
package mat_pkg;
  localparam int MAT_WIDTH = 4;

  typedef logic signed [2*MAT_WIDTH-1:0] acc_t;
  typedef logic signed [MAT_WIDTH-1:0]   elem_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam elem_t ELEM_MAX = elem_t'((2**(MAT_WIDTH-1)) - 1);
  localparam elem_t ELEM_MIN = elem_t'(-(2**(MAT_WIDTH-1)));
endpackage
`default_nettype wire

// File: rtl/mat_requant_drain_requant_sat.sv
`default_nettype none
// requant_sat: one accumulator -> one saturated element, round-half-up shift.
module requant_sat
  import mat_pkg::*;
#(
  parameter int WIDTH = MAT_WIDTH,
  parameter int SHIFT = 2
) (
  input  logic signed [2*WIDTH-1:0] acc,
  output logic signed [WIDTH-1:0]   elem,
  output logic                      sat
);
  localparam int EW = 2*WIDTH + 1;
  localparam logic signed [EW-1:0] C_MAX = EW'((1 << (WIDTH-1)) - 1);
  localparam logic signed [EW-1:0] C_MIN = ~C_MAX;

  logic signed [EW-1:0] acc_x;
  logic signed [EW-1:0] t;

  // One extra bit so the rounding add cannot overflow at the positive extreme.
  assign acc_x = {acc[2*WIDTH-1], acc};

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [EW-1:0] C_HALF = EW'(1) << (SHIFT-1);
      logic signed [EW-1:0] sum;
      assign sum = acc_x + C_HALF;
      assign t   = sum >>> SHIFT;
    end else begin : g_pass
      assign t = acc_x;
    end
  endgenerate

  always_comb begin
    elem = t[WIDTH-1:0];
    sat  = 1'b0;
    if (t > C_MAX) begin
      elem = C_MAX[WIDTH-1:0];
      sat  = 1'b1;
    end else if (t < C_MIN) begin
      elem = C_MIN[WIDTH-1:0];
      sat  = 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/mat_requant_drain.sv
`default_nettype none
// mat_requant_drain: snapshots the accumulator array on acc_valid and streams
// requantised rows over valid/ready, one row per handshake.
module mat_requant_drain
  import mat_pkg::*;
#(
  parameter int DIM   = 16,
  parameter int WIDTH = MAT_WIDTH,
  parameter int SHIFT = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [DIM*DIM*2*WIDTH-1:0]   acc_in,
  input  logic                         acc_valid,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic [DIM*WIDTH-1:0]         row_data,
  output logic [$clog2(DIM)-1:0]       row_idx,
  output logic                         row_last,
  output logic [DIM-1:0]               row_sat,
  output logic                         busy,
  output logic [7:0]                   drop_cnt
);
  localparam int IDX_W = $clog2(DIM);
  localparam logic [IDX_W-1:0] C_LAST = IDX_W'(DIM-1);

  state_e                                state_q, state_d;
  logic [IDX_W-1:0]                      idx_q, idx_d;
  logic [7:0]                            drop_q, drop_d;
  logic [DIM-1:0][DIM-1:0][2*WIDTH-1:0]  buf_q;
  logic                                  capture;
  logic                                  hs;
  logic                                  at_last;

  assign hs      = (state_q == STREAM) && row_ready;
  assign at_last = (idx_q == C_LAST);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drop_d  = drop_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (acc_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (hs && at_last) begin
          // A strobe on the final handshake chains the next frame with no bubble.
          idx_d = '0;
          if (acc_valid) capture = 1'b1;
          else           state_d = IDLE;
        end else begin
          if (hs) idx_d = idx_q + IDX_W'(1);
          if (acc_valid && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drop_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
      if (capture) buf_q <= acc_in;
    end
  end

  generate
    for (genvar c = 0; c < DIM; c++) begin : g_col
      logic [WIDTH-1:0] elem;
      requant_sat #(
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
      ) u_rq (
        .acc  (buf_q[idx_q][c]),
        .elem (elem),
        .sat  (row_sat[c])
      );
      assign row_data[c*WIDTH +: WIDTH] = elem;
    end
  endgenerate

  assign row_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign row_last  = row_valid && at_last;
  assign row_idx   = idx_q;
  assign drop_cnt  = drop_q;
endmodule
`default_nettype wire

// File: tb/tb_mat_requant_drain.sv
`default_nettype none
// Directed self-checking bench for mat_requant_drain (DIM=4, WIDTH=4, SHIFT=2).
module tb_mat_requant_drain;
  logic         clk;
  logic         reset_n;
  logic [127:0] acc_in;
  logic         acc_valid;
  logic         row_valid;
  logic         row_ready;
  logic [15:0]  row_data;
  logic [1:0]   row_idx;
  logic         row_last;
  logic [3:0]   row_sat;
  logic         busy;
  logic [7:0]   drop_cnt;

  int checks;
  int failures;

  // Frame A: rounding rows, a saturating row, then mixed rows.
  int frame_a [16] = '{13, -13, 2, -2,  40, -40, 127, -128,  1, 5, 6, -6,  0, -1, -3, 28};
  int frame_b [16] = '{-128, 4, 8, -9,  0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0};
  // Hand-computed rows, col0 in the low nibble.
  logic [15:0] exp_a [4] = '{16'h01D3, 16'h8787, 16'hF210, 16'h7F00};
  logic [3:0]  sat_a [4] = '{4'h0, 4'hF, 4'h0, 4'h0};

  mat_requant_drain #(.DIM(4), .WIDTH(4), .SHIFT(2)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .acc_in    (acc_in),
    .acc_valid (acc_valid),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .row_last  (row_last),
    .row_sat   (row_sat),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_frame(input int sel);
    for (int i = 0; i < 16; i++)
      acc_in[i*8 +: 8] = (sel == 0) ? 8'(frame_a[i]) : 8'(frame_b[i]);
  endtask

  task automatic capture(input int sel);
    load_frame(sel);
    acc_valid = 1'b1;
    step();
    acc_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; acc_valid = 1'b0; row_ready = 1'b0; acc_in = '0;
    step(); step();
    checks++;
    if ({row_valid, busy, row_last} !== 3'b000) begin
      failures++; $display("FAIL reset_ctrl: got valid/busy/last=%b want 000", {row_valid, busy, row_last});
    end
    checks++;
    if ({row_idx, drop_cnt, row_data, row_sat} !== 30'd0) begin
      failures++; $display("FAIL reset_regs: got idx=%0d drop=%0d data=%h sat=%b want all 0", row_idx, drop_cnt, row_data, row_sat);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_rounding();
    row_ready = 1'b1;
    capture(0);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 2'(r) || row_last !== (r == 3)) begin
        failures++; $display("FAIL round_ctrl r%0d: got valid=%b idx=%0d last=%b want 1 %0d %0d", r, row_valid, row_idx, row_last, r, (r == 3));
      end
      checks++;
      if (row_data !== exp_a[r] || row_sat !== sat_a[r]) begin
        failures++; $display("FAIL round_data r%0d: got data=%h sat=%b want %h %b", r, row_data, row_sat, exp_a[r], sat_a[r]);
      end
      step();
    end
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL round_idle: got valid=%b busy=%b want 0 0", row_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    row_ready = 1'b1;
    capture(0);
    cyc = 1;
    step(); cyc++;
    row_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 2'd1 || row_data !== 16'h8787 || row_sat !== 4'hF) begin
        failures++; $display("FAIL bp_hold k%0d: got valid=%b idx=%0d data=%h sat=%b want 1 1 8787 1111", k, row_valid, row_idx, row_data, row_sat);
      end
      step(); cyc++;
    end
    row_ready = 1'b1;
    while (row_valid === 1'b1 && cyc < 50) begin
      step(); cyc++;
    end
    // cyc counts edges after the capture edge until row_valid drops
    checks++;
    if (cyc - 1 !== 9) begin
      failures++; $display("FAIL bp_drain: got %0d cycles want 9", cyc - 1);
    end
  endtask

  task automatic test_drop();
    row_ready = 1'b1;
    capture(0);
    step();
    load_frame(1);
    acc_valid = 1'b1;
    step();
    checks++;
    if (drop_cnt !== 8'd1 || row_idx !== 2'd2 || row_data !== exp_a[2]) begin
      failures++; $display("FAIL drop_first: got drop=%0d idx=%0d data=%h want 1 2 %h", drop_cnt, row_idx, row_data, exp_a[2]);
    end
    step();
    acc_valid = 1'b0;
    checks++;
    if (drop_cnt !== 8'd2 || row_idx !== 2'd3 || row_data !== exp_a[3]) begin
      failures++; $display("FAIL drop_second: got drop=%0d idx=%0d data=%h want 2 3 %h", drop_cnt, row_idx, row_data, exp_a[3]);
    end
    step();
    checks++;
    if (row_valid !== 1'b0 || drop_cnt !== 8'd2) begin
      failures++; $display("FAIL drop_end: got valid=%b drop=%0d want 0 2", row_valid, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    row_ready = 1'b1;
    capture(0);
    step(); step(); step();
    checks++;
    if (row_idx !== 2'd3 || row_last !== 1'b1) begin
      failures++; $display("FAIL chain_pre: got idx=%0d last=%b want 3 1", row_idx, row_last);
    end
    load_frame(1);
    acc_valid = 1'b1;
    step();
    acc_valid = 1'b0;
    checks++;
    if (row_idx !== 2'd0 || busy !== 1'b1 || row_valid !== 1'b1 || drop_cnt !== 8'd2) begin
      failures++; $display("FAIL chain_ctrl: got idx=%0d busy=%b valid=%b drop=%0d want 0 1 1 2", row_idx, busy, row_valid, drop_cnt);
    end
    checks++;
    if (row_data !== 16'hE218 || row_sat !== 4'b0001) begin
      failures++; $display("FAIL chain_data: got data=%h sat=%b want e218 0001", row_data, row_sat);
    end
    step();
    checks++;
    if (row_idx !== 2'd1 || row_data !== 16'h0000 || row_sat !== 4'h0) begin
      failures++; $display("FAIL chain_row1: got idx=%0d data=%h sat=%b want 1 0000 0000", row_idx, row_data, row_sat);
    end
    step(); step(); step();
    checks++;
    if (row_valid !== 1'b0) begin
      failures++; $display("FAIL chain_end: got valid=%b want 0", row_valid);
    end
  endtask

  task automatic test_reset_mid();
    row_ready = 1'b1;
    capture(0);
    step(); step();
    checks++;
    if (row_idx !== 2'd2) begin
      failures++; $display("FAIL rst_mid_pre: got idx=%0d want 2", row_idx);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (row_valid !== 1'b0 || busy !== 1'b0 || row_idx !== 2'd0 || drop_cnt !== 8'd0) begin
      failures++; $display("FAIL rst_mid_async: got valid=%b busy=%b idx=%0d drop=%0d want 0 0 0 0", row_valid, busy, row_idx, drop_cnt);
    end
    step();
    reset_n = 1'b1;
    step();
    capture(0);
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (row_valid !== 1'b1 || row_idx !== 2'(r) || row_data !== exp_a[r] || row_sat !== sat_a[r]) begin
        failures++; $display("FAIL rst_restream r%0d: got valid=%b idx=%0d data=%h sat=%b want 1 %0d %h %b", r, row_valid, row_idx, row_data, row_sat, r, exp_a[r], sat_a[r]);
      end
      step();
    end
    checks++;
    if (row_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      failures++; $display("FAIL rst_restream_end: got valid=%b drop=%0d want 0 0", row_valid, drop_cnt);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_rounding();
    test_backpressure();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/mat_requant_drain.md
# mat_requant_drain

Output stage placed directly downstream of the unary matrix multiplier. On the multiplier's completion pulse it snapshots the DIM×DIM array of signed 2·WIDTH-bit accumulators and requantises each element back to signed WIDTH bits (round-half-up arithmetic shift, then saturate). It streams the result one row per handshake over a valid/ready interface. The row stream feeds the next multiply's operand loader or a host readout.

## Interface
- DIM, 16, matrix dimension; rows and columns.
- WIDTH, 4, signed operand width; output element width.
- SHIFT, 2, requantisation right-shift, legal range 0..2·WIDTH-1.
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- acc_in  input  DIM×DIM×2·WIDTH  multiplier accumulators, [row][col], two's complement.
- acc_valid  input  1  single-cycle capture strobe; connects to the multiplier's finished.
- row_valid  output  1  row_data is valid.
- row_ready  input  1  consumer accepts the row.
- row_data  output  DIM×WIDTH  requantised row, [col], two's complement.
- row_idx  output  $clog2(DIM)  index of the row currently presented.
- row_last  output  1  high when row_idx == DIM-1 and row_valid is high.
- row_sat  output  DIM  per-column flag: that element was clipped.
- busy  output  1  high in STREAM.
- drop_cnt  output  8  saturating count of discarded acc_valid strobes.

## Operation
- FSM has two states: IDLE and STREAM. Reset values: state=IDLE, row_idx=0, drop_cnt=0, snapshot buffer=0, busy=0, row_valid=0, row_last=0. row_data and row_sat derive from the buffer and row_idx, so they reset to 0.
- IDLE:
  - acc_valid=1 → latch the whole of acc_in into the buffer, set row_idx=0, go to STREAM.
- STREAM:
  - row_valid=1.
  - On row_valid & row_ready with row_idx<DIM-1, increment row_idx.
  - On the handshake with row_idx=DIM-1, return to IDLE.
- acc_valid during STREAM, other than the final-handshake cycle → no capture; drop_cnt increments, saturating at 255.
- acc_valid in the same cycle as the final handshake → capture new acc_in, row_idx=0, remain in STREAM; drop_cnt unchanged.
- Requantisation per element, computed in 2·WIDTH+1 bits:
  - SHIFT>0: t = (acc + 2^(SHIFT-1)) >>> SHIFT.
  - SHIFT=0: t = acc.
  - Result is t clamped to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. row_sat[c]=1 iff the clamp changed the value.
- Buffer is only written on capture, so it is stable while a row is presented. row_data must not change while row_valid=1 and row_ready=0.

## Timing
- Capture happens on the edge where acc_valid=1 is sampled. row_valid rises in the next cycle: latency 1.
- Minimum drain time is DIM cycles with row_ready held high. Back-to-back frames have no bubble when acc_valid coincides with the final handshake.
- row_data, row_sat and row_last are combinational from registered state only; there is no path from row_ready to any output.
- reset_n asserted mid-stream → immediate return to reset values. The in-flight frame is lost and is not counted in drop_cnt.

## Structure
- Package mat_pkg holds:
  - typedefs acc_t (logic signed [2·WIDTH-1:0]) and elem_t (logic signed [WIDTH-1:0]);
  - the FSM state enum (IDLE, STREAM);
  - function-free constants ELEM_MAX and ELEM_MIN.
- Sub-module requant_sat: one element, purely combinational, ports acc → elem, sat. It is instantiated DIM times on the selected buffer row, not DIM² times.

## Test plan
All scenarios use WIDTH=4, SHIFT=2, DIM=4.
- Rounding:
  - Stimulus: row 0 = {13, -13, 2, -2}, acc_valid pulse, row_ready=1.
  - Required: next cycle row_data = {3, -3, 1, 0}, row_sat=0000, row_idx=0.
  - Then row_idx steps 1, 2, 3 on consecutive cycles; row_last is high only at row_idx 3.
- Saturation:
  - Stimulus: row 0 = {40, -40, 127, -128}.
  - Required: row_data = {7, -8, 7, -8}, row_sat=1111.
- Backpressure:
  - Stimulus: hold row_ready=0 for 5 cycles at row_idx=1, then release.
  - Required: row_valid stays 1 and row_data/row_idx stay constant throughout; the drain finishes DIM+5 cycles after capture.
- Drop:
  - Stimulus: pulse acc_valid at row_idx=1 and again at row_idx=2.
  - Required: drop_cnt=2, and the streamed data equals the first snapshot.
- Chaining:
  - Stimulus: acc_valid coincides with the row 3 handshake.
  - Required: the next cycle shows row_idx=0 with the new data, busy stays 1, drop_cnt unchanged.
- Reset mid-stream:
  - Stimulus: deassert reset_n at row_idx=2.
  - Required: row_valid=0, busy=0, row_idx=0 and drop_cnt=0 asynchronously. A fresh acc_valid after release streams normally.
